// File: rtl/ibex_bp_pkg.sv
// ============================================================================
// Module : ibex_bp_pkg
// Brief  : Shared types and constants for the static branch predictor control.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ibex_bp_pkg;

  typedef enum logic [0:0] {
    BP_RUN    = 1'b0,
    BP_SQUASH = 1'b1
  } bp_ctrl_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        compressed;
  } bp_track_entry_t;

  localparam logic [31:0] PC_INCR_C = 32'd2;
  localparam logic [31:0] PC_INCR_W = 32'd4;

  // Address of the instruction following a tracked branch, wrapping at 2^32.
  function automatic logic [31:0] bp_fall_through(input bp_track_entry_t e);
    return e.pc + (e.compressed ? PC_INCR_C : PC_INCR_W);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ibex_bp_track_fifo.sv
// ============================================================================
// Module : ibex_bp_track_fifo
// Brief  : In-order FIFO of acted-on predictions awaiting EX resolution.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_bp_track_fifo
  import ibex_bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  bp_track_entry_t          data_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output bp_track_entry_t          head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_C = (PTR_W+1)'(DEPTH);

  bp_track_entry_t    mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [PTR_W:0]     count_q;
  logic               do_push, do_pop;

  assign full_o  = (count_q == FULL_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  // Flush outranks both push and pop; full is sampled before any pop.
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/ibex_branch_predict_ctrl.sv
// ============================================================================
// Module : ibex_branch_predict_ctrl
// Brief  : Turns taken predictions into redirects and recovers on mispredicts.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_branch_predict_ctrl
  import ibex_bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     bp_enable_i,
  input  logic                     fetch_valid_i,
  input  logic                     fetch_ready_i,
  input  logic [31:0]              fetch_pc_i,
  input  logic                     fetch_is_compressed_i,
  input  logic                     predict_taken_i,
  input  logic [31:0]              predict_pc_i,
  input  logic                     resolve_valid_i,
  input  logic                     resolve_taken_i,
  output logic                     redirect_o,
  output logic [31:0]              redirect_pc_o,
  output logic                     fetch_drop_o,
  output logic                     fetch_hold_o,
  output logic                     mispredict_o,
  output logic [31:0]              mispredict_pc_o,
  output logic [$clog2(DEPTH):0]   track_count_o,
  output logic [CNT_W-1:0]         predict_cnt_o,
  output logic [CNT_W-1:0]         mispredict_cnt_o
);

  bp_ctrl_state_e   state_q;
  logic             redirect_q, mispredict_q;
  logic [31:0]      redirect_pc_q, mispredict_pc_q;
  logic [CNT_W-1:0] predict_cnt_q, mispredict_cnt_q;

  logic             fifo_full, fifo_empty;
  bp_track_entry_t  fifo_head, fifo_in;
  logic             take, mp, pop, push;

  always_comb begin
    take = fetch_valid_i & fetch_ready_i & bp_enable_i & predict_taken_i &
           (state_q == BP_RUN) & ~fifo_full;
    pop  = resolve_valid_i & ~fifo_empty;
    mp   = pop & ~resolve_taken_i;
    push = take & ~mp;
    fifo_in.pc         = fetch_pc_i;
    fifo_in.compressed = fetch_is_compressed_i;
  end

  ibex_bp_track_fifo #(
    .DEPTH (DEPTH)
  ) u_track_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (mp),
    .data_i  (fifo_in),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (track_count_o),
    .head_o  (fifo_head)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= BP_RUN;
      redirect_q       <= 1'b0;
      redirect_pc_q    <= '0;
      mispredict_q     <= 1'b0;
      mispredict_pc_q  <= '0;
      predict_cnt_q    <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      unique case (state_q)
        BP_RUN:    state_q <= push ? BP_SQUASH : BP_RUN;
        BP_SQUASH: state_q <= BP_RUN;
        default:   state_q <= BP_RUN;
      endcase

      // Recovery outranks any redirect registered for the same cycle.
      redirect_q   <= push & ~mp;
      mispredict_q <= mp;

      if (push) begin
        redirect_pc_q <= predict_pc_i;
        if (predict_cnt_q != '1) predict_cnt_q <= predict_cnt_q + CNT_W'(1);
      end

      if (mp) begin
        mispredict_pc_q <= bp_fall_through(fifo_head);
        if (mispredict_cnt_q != '1) mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
      end
    end
  end

  assign redirect_o       = redirect_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign mispredict_o     = mispredict_q;
  assign mispredict_pc_o  = mispredict_pc_q;
  assign predict_cnt_o    = predict_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;
  assign fetch_drop_o     = (state_q == BP_SQUASH);
  assign fetch_hold_o     = fetch_valid_i & predict_taken_i & bp_enable_i & fifo_full;

endmodule

`default_nettype wire

// File: tb/tb_ibex_branch_predict_ctrl.sv
// ============================================================================
// Module : tb_ibex_branch_predict_ctrl
// Brief  : Directed and random checks of the branch predictor control block.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ibex_branch_predict_ctrl;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        bp_enable_i, fetch_valid_i, fetch_ready_i, fetch_is_compressed_i;
  logic [31:0] fetch_pc_i, predict_pc_i;
  logic        predict_taken_i, resolve_valid_i, resolve_taken_i;
  logic        redirect_o, fetch_drop_o, fetch_hold_o, mispredict_o;
  logic [31:0] redirect_pc_o, mispredict_pc_o;
  logic [$clog2(DEPTH):0] track_count_o;
  logic [CNT_W-1:0] predict_cnt_o, mispredict_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a plain queue of {pc, compressed} plus expected outputs.
  logic [32:0] mq[$];
  bit          m_squash, m_redir, m_mp;
  logic [31:0] m_rpc, m_mpc;
  int          m_pcnt, m_mcnt;

  always #5 clk_i = ~clk_i;

  ibex_branch_predict_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .bp_enable_i           (bp_enable_i),
    .fetch_valid_i         (fetch_valid_i),
    .fetch_ready_i         (fetch_ready_i),
    .fetch_pc_i            (fetch_pc_i),
    .fetch_is_compressed_i (fetch_is_compressed_i),
    .predict_taken_i       (predict_taken_i),
    .predict_pc_i          (predict_pc_i),
    .resolve_valid_i       (resolve_valid_i),
    .resolve_taken_i       (resolve_taken_i),
    .redirect_o            (redirect_o),
    .redirect_pc_o         (redirect_pc_o),
    .fetch_drop_o          (fetch_drop_o),
    .fetch_hold_o          (fetch_hold_o),
    .mispredict_o          (mispredict_o),
    .mispredict_pc_o       (mispredict_pc_o),
    .track_count_o         (track_count_o),
    .predict_cnt_o         (predict_cnt_o),
    .mispredict_cnt_o      (mispredict_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_squash = 0; m_redir = 0; m_mp = 0;
    m_rpc = 0; m_mpc = 0; m_pcnt = 0; m_mcnt = 0;
  endtask

  task automatic drive(input bit fv, input bit fr, input bit en, input bit pt,
                       input logic [31:0] pc, input bit c, input logic [31:0] ppc,
                       input bit rv, input bit rt);
    fetch_valid_i = fv; fetch_ready_i = fr; bp_enable_i = en; predict_taken_i = pt;
    fetch_pc_i = pc; fetch_is_compressed_i = c; predict_pc_i = ppc;
    resolve_valid_i = rv; resolve_taken_i = rt;
  endtask

  task automatic idle();
    drive(0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  // Apply the rules of one clock edge to the model using the current inputs.
  task automatic model_edge();
    bit full, empty, take, mp;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    take  = fetch_valid_i && fetch_ready_i && bp_enable_i && predict_taken_i && !m_squash && !full;
    mp    = resolve_valid_i && !empty && !resolve_taken_i;
    m_mp  = mp;
    m_redir = 0;
    if (mp) begin
      m_mpc = mq[0][32:1] + (mq[0][0] ? 32'd2 : 32'd4);
      mq.delete();
      if (m_mcnt < CMAX) m_mcnt++;
      m_squash = 0;
    end else begin
      if (resolve_valid_i && !empty) void'(mq.pop_front());
      if (take) begin
        mq.push_back({fetch_pc_i, fetch_is_compressed_i});
        m_redir = 1;
        m_rpc = predict_pc_i;
        if (m_pcnt < CMAX) m_pcnt++;
      end
      m_squash = take;
    end
  endtask

  // Entered and left one time unit after a rising edge.
  task automatic step();
    #3;
    chk("fetch_hold", fetch_hold_o,
        fetch_valid_i && predict_taken_i && bp_enable_i && (mq.size() == DEPTH));
    chk("fetch_drop", fetch_drop_o, m_squash);
    @(posedge clk_i);
    model_edge();
    #1;
    chk("redirect", redirect_o, m_redir);
    chk("redirect_pc", redirect_pc_o, m_rpc);
    chk("mispredict", mispredict_o, m_mp);
    if (m_mp) chk("mispredict_pc", mispredict_pc_o, m_mpc);
    chk("track_count", track_count_o, mq.size());
    chk("predict_cnt", predict_cnt_o, m_pcnt);
    chk("mispredict_cnt", mispredict_cnt_o, m_mcnt);
  endtask

  task automatic take_one(input logic [31:0] pc, input bit c, input logic [31:0] tgt);
    drive(1, 1, 1, 1, pc, c, tgt, 0, 0); step();
    idle(); step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_redirect"}, redirect_o, 0);
    chk({tag, "_redirect_pc"}, redirect_pc_o, 0);
    chk({tag, "_drop"}, fetch_drop_o, 0);
    chk({tag, "_hold"}, fetch_hold_o, 0);
    chk({tag, "_mispredict"}, mispredict_o, 0);
    chk({tag, "_mispredict_pc"}, mispredict_pc_o, 0);
    chk({tag, "_count"}, track_count_o, 0);
    chk({tag, "_pcnt"}, predict_cnt_o, 0);
    chk({tag, "_mcnt"}, mispredict_cnt_o, 0);
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    model_reset();
    #1;
    chk_all_zero("reset");
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Taken prediction and its redirect.
    drive(1, 1, 1, 1, 32'h100, 0, 32'h0F0, 0, 0); step();
    chk("t1_redirect", redirect_o, 1);
    chk("t1_redirect_pc", redirect_pc_o, 32'h0F0);
    chk("t1_drop", fetch_drop_o, 1);
    chk("t1_count", track_count_o, 1);
    chk("t1_pcnt", predict_cnt_o, 1);

    // Resolve taken: silent pop.
    drive(0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 1); step();
    chk("t2_mispredict", mispredict_o, 0);
    chk("t2_count", track_count_o, 0);

    // Compressed branch resolved not-taken.
    drive(1, 1, 1, 1, 32'h200, 1, 32'h300, 0, 0); step();
    drive(0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 0); step();
    chk("t3_mispredict", mispredict_o, 1);
    chk("t3_mispredict_pc", mispredict_pc_o, 32'h202);
    chk("t3_mcnt", mispredict_cnt_o, 1);
    chk("t3_count", track_count_o, 0);

    // Fill the FIFO, then a fifth prediction is held off.
    for (int i = 0; i < DEPTH; i++) take_one(32'h1000 + 32'(i * 4), 0, 32'h2000 + 32'(i * 16));
    chk("t4_full_count", track_count_o, DEPTH);
    drive(1, 1, 1, 1, 32'h1010, 0, 32'h5000, 0, 0);
    #3;
    chk("t4_hold", fetch_hold_o, 1);
    #2; @(negedge clk_i); #0;
    rst_i = 1'b0;
    @(posedge clk_i); model_edge(); #1;
    chk("t4_no_redirect", redirect_o, 0);
    chk("t4_count_stays", track_count_o, DEPTH);
    drive(1, 1, 1, 1, 32'h1010, 0, 32'h5000, 1, 1); step();
    chk("t4_pop_count", track_count_o, DEPTH - 1);
    drive(1, 1, 1, 1, 32'h1010, 0, 32'h5000, 0, 0); step();
    chk("t4_accept_redirect", redirect_o, 1);
    chk("t4_accept_pc", redirect_pc_o, 32'h5000);
    chk("t4_accept_count", track_count_o, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 1); step();
    end
    chk("t4_drained", track_count_o, 0);

    // Mispredict collides with a new take.
    take_one(32'h400, 0, 32'h800);
    take_one(32'h404, 1, 32'h900);
    drive(1, 1, 1, 1, 32'h408, 0, 32'hA00, 1, 0); step();
    chk("t5_mispredict", mispredict_o, 1);
    chk("t5_mispredict_pc", mispredict_pc_o, 32'h404);
    chk("t5_redirect", redirect_o, 0);
    chk("t5_count", track_count_o, 0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 9,
            $urandom_range(0, 1) == 1, {$urandom} & 32'hFFFF_FFFE, $urandom_range(0, 1) == 1,
            {$urandom} & 32'hFFFF_FFFE, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6);
      step();
    end

    // Drive the mispredict counter into saturation.
    idle(); step();
    for (int i = 0; i < CMAX + 3; i++) begin
      drive(1, 1, 1, 1, 32'hFFFF_FFFC, 0, 32'h40, 0, 0); step();
      drive(0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 0); step();
    end
    chk("sat_mcnt", mispredict_cnt_o, CMAX);
    chk("sat_pcnt", predict_cnt_o, CMAX);
    chk("wrap_mispredict_pc", mispredict_pc_o, 32'h0);

    // Asynchronous reset while in SQUASH.
    drive(1, 1, 1, 1, 32'h600, 0, 32'h700, 0, 0); step();
    chk("pre_rst_drop", fetch_drop_o, 1);
    idle();
    #2;
    rst_i = 1'b1;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    drive(1, 1, 1, 1, 32'h120, 0, 32'h140, 0, 0); step();
    chk("post_rst_redirect", redirect_o, 1);
    idle(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ibex_branch_predict_ctrl.md
Name: ibex_branch_predict_ctrl

Overview:
Sequences the static fetch-stage branch predictor. It turns taken predictions into registered redirect requests to the prefetch buffer and drops the one wrong-path instruction. It also tracks every acted-on prediction in order until EX resolves it, and raises a mispredict recovery with the fall-through PC when the branch was not taken. It sits between the predictor, the IF/ID handshake and the EX branch-resolution port, and keeps saturating statistics counters.

Parameters:
DEPTH, 4, tracking-FIFO entries; power of two, >=2
CNT_W, 16, width of saturating statistics counters

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
bp_enable_i  in  1  acting on new predictions permitted
fetch_valid_i  in  1  fetch stage presents an instruction
fetch_ready_i  in  1  ID accepts the presented instruction this cycle
fetch_pc_i  in  32  PC of the presented instruction
fetch_is_compressed_i  in  1  presented instruction is 16-bit
predict_taken_i  in  1  predictor output for the presented instruction
predict_pc_i  in  32  predicted target
resolve_valid_i  in  1  EX resolves the oldest tracked branch
resolve_taken_i  in  1  actual outcome of that branch
redirect_o  out  1  one-cycle redirect request to prefetch buffer
redirect_pc_o  out  32  redirect target
fetch_drop_o  out  1  squash the instruction presented this cycle
fetch_hold_o  out  1  stall IF/ID; the tracking FIFO is full
mispredict_o  out  1  one-cycle recovery request
mispredict_pc_o  out  32  recovery PC (fall-through)
track_count_o  out  $clog2(DEPTH)+1  outstanding tracked branches
predict_cnt_o  out  CNT_W  predictions acted on
mispredict_cnt_o  out  CNT_W  mispredictions

Behaviour:
- Reset (async, rst_i=1): every output 0; FIFO empty; state RUN; counters 0. Reset mid-redirect discards the pending redirect.
- Definitions:
  - take = fetch_valid_i & fetch_ready_i & bp_enable_i & predict_taken_i & state==RUN & !full.
  - mp = resolve_valid_i & !empty & !resolve_taken_i.
- FSM has two states, RUN and SQUASH.
- RUN to SQUASH when take & !mp.
- SQUASH always returns to RUN next cycle.
- fetch_drop_o = (state==SQUASH).
- take & !mp:
  - Push {fetch_pc_i, fetch_is_compressed_i}.
  - Next cycle: redirect_o=1 and redirect_pc_o=predict_pc_i (registered, latency 1).
  - predict_cnt_o increments.
- redirect_pc_o holds its last value when redirect_o=0.
- fetch_hold_o = fetch_valid_i & predict_taken_i & bp_enable_i & full (combinational). No push while full.
- resolve_valid_i & !empty pops the head.
  - resolve_taken_i=1: silent pop.
  - resolve_taken_i=0 (mp): next cycle mispredict_o=1 and mispredict_pc_o = head.pc + (compressed ? 2 : 4), modulo 2^32.
  - mp also empties the FIFO, forces state RUN, suppresses any same-cycle take (no push, no redirect) and increments mispredict_cnt_o.
- resolve_valid_i with an empty FIFO is ignored.
- Simultaneous non-mispredicting pop and take: both occur; count unchanged. Push into a full FIFO in the same cycle as a pop is not allowed (full is evaluated before the pop).
- A redirect issued in cycle N and a mispredict in cycle N are mutually exclusive by construction. If both are registered for the same cycle, mispredict_o wins and redirect_o is forced 0.
- bp_enable_i low: no new takes. Outstanding entries still resolve normally.
- Counters saturate at all-ones. They do not wrap.
- FIFO pointers wrap modulo DEPTH. track_count_o ranges 0..DEPTH.

Decomposition:
- Package ibex_bp_pkg holds:
  - state enum bp_ctrl_state_e {BP_RUN, BP_SQUASH}
  - struct bp_track_entry_t {pc[31:0], compressed}
  - constants PC_INCR_C=2 and PC_INCR_W=4
- Sub-module ibex_bp_track_fifo (parameter DEPTH): push, pop, flush, full, empty, count and head. flush has priority over push.

Test Plan:
- Taken prediction, pc=0x100, target=0x0F0, fetch_ready_i=1 -> next cycle redirect_o=1, redirect_pc_o=0x0F0, fetch_drop_o=1; track_count_o=1; predict_cnt_o=1.
- Resolve taken on the entry above -> no mispredict_o; track_count_o=0.
- Compressed branch at 0x200 pushed, then resolve not-taken -> next cycle mispredict_o=1, mispredict_pc_o=0x202, mispredict_cnt_o=1, FIFO empty.
- Fill 4 entries with no resolves, then a 5th taken prediction -> fetch_hold_o=1, no redirect, count stays 4. Resolve taken -> hold drops and the 5th prediction is accepted.
- With 2 entries queued, a not-taken resolve arrives in the same cycle as a new take -> mispredict_o next cycle, redirect_o=0, track_count_o=0.
- rst_i asserted during SQUASH; counters preloaded to all-ones, then a further mispredict -> all outputs 0 immediately on reset; in the saturation case mispredict_cnt_o stays 0xFFFF.
